// File: rtl/hex_display_pkg.sv
// Shared constants and helpers for the multiplexed hex display driver.
package hex_display_pkg;

  // All segments off (active-low bus).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment patterns, bit6=g ... bit0=a, indexed by nibble value.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // Counter width for a modulus of n; never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = hex_to_seg_n(nibble_i);

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed N-digit hex display driver with leading-zero blanking
// and per-digit blink, scanning one shared active-low segment bus.
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_TICKS = 250
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   dig_en_n,
  output logic                    slot_tick
);

  localparam int IDX_W = width_of(NUM_DIGITS);
  localparam int PRE_W = width_of(REFRESH_DIV);
  localparam int BLK_W = width_of(BLINK_TICKS);

  logic [4*NUM_DIGITS-1:0] shadow_q,    shadow_d;
  logic [PRE_W-1:0]        prescaler_q, prescaler_d;
  logic [IDX_W-1:0]        index_q,     index_d;
  logic [BLK_W-1:0]        blink_cnt_q, blink_cnt_d;
  logic                    phase_q,     phase_d;
  logic                    slot_tick_q, slot_tick_d;
  logic [6:0]              seg_n_q,     seg_n_d;
  logic [NUM_DIGITS-1:0]   dig_en_n_q,  dig_en_n_d;

  logic       tick;
  logic [3:0] cur_digit;
  logic       cur_blink;
  logic       lz_blank;
  logic [6:0] dec_seg_n;

  hex_seg_decode u_decode (
    .nibble_i (cur_digit),
    .seg_n_o  (dec_seg_n)
  );

  // Scan timing: prescaler, digit index, blink counter/phase and shadow load.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    tick        = (prescaler_q == PRE_W'(REFRESH_DIV - 1));
    prescaler_d = tick ? '0 : prescaler_q + PRE_W'(1);
    slot_tick_d = tick;
    index_d     = index_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    shadow_d    = load ? value : shadow_q;
    if (tick) begin
      index_d = (index_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : index_q + IDX_W'(1);
      if (blink_cnt_q == BLK_W'(BLINK_TICKS - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
  end

  // Display path: select current digit, apply blanking, drive one enable low.
  always_comb begin
    cur_digit  = 4'h0;
    cur_blink  = 1'b0;
    dig_en_n_d = '1;
    // Digit 0 is never leading-zero blanked, so a zero value still shows "0".
    lz_blank   = blank_lz && (index_q != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == index_q) begin
        cur_digit     = shadow_q[4*i +: 4];
        cur_blink     = blink_en[i];
        dig_en_n_d[i] = 1'b0;
      end
      // Any non-zero digit at or above the current one means it is significant.
      if ((IDX_W'(i) >= index_q) && (shadow_q[4*i +: 4] != 4'h0)) begin
        lz_blank = 1'b0;
      end
    end
    seg_n_d = (lz_blank || (cur_blink && phase_q)) ? SEG_BLANK : dec_seg_n;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      shadow_q    <= '0;
      prescaler_q <= '0;
      index_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      slot_tick_q <= 1'b0;
      seg_n_q     <= SEG_BLANK;
      dig_en_n_q  <= '1;
    end else begin
      shadow_q    <= shadow_d;
      prescaler_q <= prescaler_d;
      index_q     <= index_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      slot_tick_q <= slot_tick_d;
      seg_n_q     <= seg_n_d;
      dig_en_n_q  <= dig_en_n_d;
    end
  end

  assign seg_n     = seg_n_q;
  assign dig_en_n  = dig_en_n_q;
  assign slot_tick = slot_tick_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner: the stimulus thread queues
// hand-computed expectations tagged with a cycle number; a monitor on the
// falling edge pops and compares them against the DUT outputs.
module tb_hex_display_scanner;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BT = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [4*ND-1:0] value;
  logic          load;
  logic          blank_lz;
  logic [ND-1:0] blink_en;
  logic [6:0]    seg_n;
  logic [ND-1:0] dig_en_n;
  logic          slot_tick;

  hex_display_scanner #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLINK_TICKS (BT)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .value     (value),
    .load      (load),
    .blank_lz  (blank_lz),
    .blink_en  (blink_en),
    .seg_n     (seg_n),
    .dig_en_n  (dig_en_n),
    .slot_tick (slot_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [6:0] seg;
    logic [3:0] dig;
    logic       tick;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc       = 0;
  int   base      = 0;
  int   n_tests   = 0;
  int   n_fail    = 0;
  bit   finishing = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due at this cycle; flush stale ones.
  always @(negedge clk) begin
    while (sb.size() > 0 && (sb[0].cyc <= cyc || finishing)) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d never compared (now %0d)", e.name, e.cyc, cyc);
      end else if (seg_n !== e.seg || dig_en_n !== e.dig || slot_tick !== e.tick) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got seg_n=%b dig_en_n=%b slot_tick=%b, expected seg_n=%b dig_en_n=%b slot_tick=%b",
                 e.name, cyc, seg_n, dig_en_n, slot_tick, e.seg, e.dig, e.tick);
      end
    end
  end

  task automatic push(input int r, input logic [6:0] seg, input logic [3:0] dig,
                      input logic tick, input string name);
    exp_t e;
    e.cyc  = base + r;
    e.seg  = seg;
    e.dig  = dig;
    e.tick = tick;
    e.name = name;
    sb.push_back(e);
  endtask

  // Steady display over cycles r0..r1 after the reset base; a slot tick is
  // visible every RD cycles counted from reset release.
  task automatic push_rng(input int r0, input int r1, input logic [6:0] seg,
                          input logic [3:0] dig, input string name);
    for (int r = r0; r <= r1; r++)
      push(r, seg, dig, (r != 0) && (r % RD == 0), name);
  endtask

  task automatic wait_r(input int r);
    while (cyc < base + r) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    base  = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    value    = 16'hFFFF;
    load     = 1'b1;        // load held during reset must be ignored
    blank_lz = 1'b0;
    blink_en = '0;

    // Reset state, then digit 0 showing "0" (shadow cleared despite load).
    do_reset();
    load = 1'b0;
    push(0, 7'h7F, 4'hF, 1'b0, "reset_state");
    push_rng(1, 4, 7'b1000000, 4'b1110, "after_reset_dig0");
    push_rng(5, 5, 7'b1000000, 4'b1101, "after_reset_dig1");
    wait_r(6);

    // Scan of 0x1234 without blanking.
    do_reset();
    value = 16'h1234; load = 1'b1;
    push_rng(1, 1,  7'b1000000, 4'b1110, "scan_preload");
    push_rng(2, 4,  7'b0011001, 4'b1110, "scan_d0_4");
    push_rng(5, 8,  7'b0110000, 4'b1101, "scan_d1_3");
    push_rng(9, 12, 7'b0100100, 4'b1011, "scan_d2_2");
    push_rng(13, 16, 7'b1111001, 4'b0111, "scan_d3_1");
    push_rng(17, 20, 7'b0011001, 4'b1110, "scan_wrap_d0");
    wait_r(1); load = 1'b0;
    wait_r(21);

    // Leading-zero blanking of 0x00A0, then of 0x0000.
    do_reset();
    value = 16'h00A0; load = 1'b1; blank_lz = 1'b1;
    push_rng(1, 4,   7'b1000000, 4'b1110, "lz_d0");
    push_rng(5, 8,   7'b0001000, 4'b1101, "lz_d1_A");
    push_rng(9, 12,  7'h7F,      4'b1011, "lz_d2_blank");
    push_rng(13, 16, 7'h7F,      4'b0111, "lz_d3_blank");
    push_rng(17, 20, 7'b1000000, 4'b1110, "lz0_d0_zero");
    push_rng(21, 24, 7'h7F,      4'b1101, "lz0_d1_blank");
    push_rng(25, 28, 7'h7F,      4'b1011, "lz0_d2_blank");
    wait_r(1);  load = 1'b0;
    wait_r(16); value = 16'h0000; load = 1'b1;
    wait_r(17); load = 1'b0;
    wait_r(29);
    blank_lz = 1'b0;

    // Blink on digit 2 of 0x8888; phase flips every BT slots.
    do_reset();
    value = 16'h8888; load = 1'b1; blink_en = 4'b0100;
    push_rng(2, 4,   7'b0000000, 4'b1110, "blink_d0_steady");
    push_rng(9, 12,  7'b0000000, 4'b1011, "blink_d2_phase0");
    push_rng(13, 16, 7'b0000000, 4'b0111, "blink_d3_steady_phase1");
    push_rng(25, 28, 7'b0000000, 4'b1011, "blink_d2_phase0_again");
    push_rng(41, 44, 7'h7F,      4'b1011, "blink_d2_phase1_off");
    push_rng(45, 45, 7'b0000000, 4'b0111, "blink_d3_after");
    wait_r(1); load = 1'b0;
    wait_r(46);
    blink_en = '0;

    // Load coinciding with a tick edge.
    do_reset();
    value = 16'h1111; load = 1'b1;
    push_rng(2, 4, 7'b1111001, 4'b1110, "tickload_old");
    push_rng(5, 6, 7'b0001110, 4'b1101, "tickload_new_F");
    wait_r(1); load = 1'b0;
    wait_r(3); value = 16'hFFFF; load = 1'b1;
    wait_r(4); load = 1'b0;
    wait_r(7);

    // Reset in the middle of a slot during blink phase 1.
    do_reset();
    value = 16'h8888; load = 1'b1; blink_en = 4'b0100;
    push_rng(9, 12,  7'b0000000, 4'b1011, "midrst_d2_phase0");
    push_rng(13, 14, 7'b0000000, 4'b0111, "midrst_d3");
    push(15, 7'h7F, 4'hF, 1'b0, "midrst_reset_vals");
    wait_r(1);  load = 1'b0;
    wait_r(14); reset = 1'b1;
    wait_r(15); reset = 1'b0;
    base = cyc;
    push_rng(1, 4,  7'b1000000, 4'b1110, "postrst_first_tick");
    push_rng(5, 8,  7'b1000000, 4'b1101, "postrst_d1");
    push_rng(9, 12, 7'b1000000, 4'b1011, "postrst_phase_cleared");
    wait_r(13);

    finishing = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
